// File: rtl/multicore_pkg.sv
// Shared constants and types for the multicore Taylor network sample path.
package multicore_pkg;

  localparam int N_CORES  = 35;
  localparam int SAMPLE_W = 19;
  localparam int OUT_W    = 28;

  localparam logic [3:0] REQ_CODE = 4'd1;

  typedef enum logic [1:0] {
    EMPTY,
    PRIMED,
    STARVED
  } feeder_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible combinationally.
module sample_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign fill     = count;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/multicore_sample_feeder.sv
// Buffers upstream samples and advances the broadcast sample on any core request.
module multicore_sample_feeder #(
  parameter int N_CORES  = multicore_pkg::N_CORES,
  parameter int SAMPLE_W = multicore_pkg::SAMPLE_W,
  parameter int DEPTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SAMPLE_W-1:0]     s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [4*N_CORES-1:0]    req_in,
  output logic [SAMPLE_W-1:0]     sample_out,
  output logic                    sample_valid,
  output logic                    underrun,
  output logic [$clog2(DEPTH):0]  fill,
  output logic [31:0]             served
);

  import multicore_pkg::*;

  feeder_state_t        state;
  logic                 req_any;
  logic                 push_ok;
  logic                 bypass;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [SAMPLE_W-1:0]  fifo_data;

  always_comb begin
    req_any = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      if (req_in[4*k +: 4] == REQ_CODE) req_any = 1'b1;
    end
  end

  assign s_ready   = !fifo_full;
  assign push_ok   = s_valid && s_ready;
  // While starved the FIFO is empty, so the first arrival goes straight out.
  assign bypass    = (state == STARVED) && push_ok;
  assign fifo_push = push_ok && !bypass;
  assign fifo_pop  = !fifo_empty &&
                     ((state == EMPTY) || ((state == PRIMED) && req_any));

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      served       <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (!fifo_empty) begin
            sample_out   <= fifo_data;
            sample_valid <= 1'b1;
            served       <= served + 32'd1;
            state        <= PRIMED;
          end
        end
        PRIMED: begin
          if (req_any) begin
            if (!fifo_empty) begin
              sample_out <= fifo_data;
              served     <= served + 32'd1;
            end else begin
              underrun <= 1'b1;
              state    <= STARVED;
            end
          end
        end
        STARVED: begin
          if (push_ok) begin
            sample_out <= s_data;
            served     <= served + 32'd1;
            state      <= PRIMED;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/multicore_sample_feeder.md
# multicore_sample_feeder

Feeds the shared signed input-sample bus of the multicore Taylor network and answers the cores' `req_in` sample requests. It buffers an upstream valid/ready sample stream in a small FIFO and advances the broadcast sample whenever any core requests one, so the network consumes samples from hardware rather than from a file. It sits between the sample source and the `in` port of `multicore`.

## Interface
- `N_CORES`, 35, number of cores; width of the request bus is 4*N_CORES
- `SAMPLE_W`, 19, signed sample width
- `DEPTH`, 16, FIFO depth; power of two, >= 2
- `clk` input 1: single clock; all state on rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `s_data` input SAMPLE_W: upstream sample, signed
- `s_valid` input 1: upstream sample valid
- `s_ready` output 1: FIFO can accept; = (fill != DEPTH), combinational from registered fill
- `req_in` input 4*N_CORES: core k request code at bits [4k+3:4k]
- `sample_out` output SAMPLE_W: broadcast sample to all cores, registered
- `sample_valid` output 1: `sample_out` holds a real sample
- `underrun` output 1: sticky; set when a request arrives with no data available
- `fill` output $clog2(DEPTH)+1: FIFO occupancy
- `served` output 32: count of samples issued on `sample_out`, wraps at 2^32

## Operation
- Request: core k requests when its field equals 4'd1; any other code ignored. `req_any` = OR over all cores; several simultaneous requests = one advance.
- Push: `s_valid && s_ready` at an edge writes `s_data` to FIFO tail (except STARVED bypass below).
- States (registered):
  - EMPTY: no sample yet. If FIFO non-empty: pop head into `sample_out`, `sample_valid`<=1, `served`++, -> PRIMED. Requests in EMPTY ignored (no underrun).
  - PRIMED: on `req_any`: if FIFO non-empty, pop head into `sample_out`, `served`++, stay; else `underrun`<=1, `sample_out` held, -> STARVED.
  - STARVED: first accepted push bypasses FIFO: `s_data` -> `sample_out` same edge, `served`++, -> PRIMED. Further `req_any` in STARVED ignored (still one pending).
- Pop and push same edge: both happen; `fill` unchanged.
- `s_ready` low when full; no overwrite. Empty pop never occurs.
- `underrun` clears only on reset.
- Sign preserved bit-exact; no arithmetic on data.

## Timing
- Reset values: `sample_out`=0, `sample_valid`=0, `underrun`=0, `fill`=0, `served`=0, state EMPTY; `s_ready`=1 after reset.
- Push at edge t is visible in `fill` after t; earliest pop of that entry at edge t+1.
- Priming: first push at edge t -> `sample_out` valid after edge t+1.
- Request sampled at edge t -> new `sample_out` after edge t (1-cycle response), as cores see it on the next edge.
- STARVED bypass: zero added latency; data on `sample_out` after the accepting edge.
- FIFO pointers wrap modulo DEPTH; `fill` ranges 0..DEPTH.
- Reset asserted mid-operation: all state cleared immediately, FIFO contents discarded.

## Structure
- Shared package `multicore_pkg`: `N_CORES`, `SAMPLE_W`, `OUT_W` (28), `REQ_CODE` (4'd1), feeder state enum {EMPTY, PRIMED, STARVED}.
- One sub-module: `sample_fifo` (sync FIFO, parameters width/depth, push/pop/full/empty/fill). Feeder FSM, request OR-reduce and counters in top.

## Test plan
- Reset then push 5, -3, 7 on consecutive cycles, no requests -> `sample_out`=5, `sample_valid`=1, `fill`=2, `served`=1.
- From that state, core 0 field=1 for one cycle -> `sample_out`=-3 next edge, `served`=2; core 3 field=4'd2 -> no change.
- Cores 0, 17, 34 all field=1 in same cycle -> single advance to 7, `served`=3, `fill`=0.
- Request with FIFO empty -> `underrun`=1, `sample_out` holds 7; then push -262144 -> `sample_out`=-262144 on accepting edge, `fill` stays 0.
- Fill 16 entries with no requests -> `s_ready`=0, `fill`=16, extra `s_valid` data dropped; request with push same edge -> `fill` stays consistent, no overwrite.
- Assert `rst_n`=0 mid-stream, asynchronously -> all outputs to reset values before next edge; resume from EMPTY.
